// File: rtl/blob_classifier_param.sv
// blob_classifier_param: single-pass connected-component labelling over a
// binarised raster frame. Parents are merged by minimum label, and three
// sweeps over the label table follow: merge areas, find the largest blob,
// then classify blobs as noise, smaller or bigger.
// Optional macro BLOB_8CONN_EN adds the up-left and up-right neighbours
// (8-connectivity). Without it the design uses 4-connectivity (left, up).
module blob_classifier_param #(
  parameter int IMG_W       = 800,
  parameter int IMG_H       = 600,
  parameter int LBL_W       = 7,
  parameter int AREA_W      = 20,
  parameter int NOISE_SHIFT = 3,
  parameter int BIG_MIN     = 200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_sof,
  input  logic       i_pixel,
  output logic       o_busy,
  output logic       o_valid,
  output logic [7:0] o_count,
  output logic [7:0] o_bigger,
  output logic [7:0] o_smaller,
  output logic       o_overflow
);
  localparam int MAX_LABELS = 2 ** LBL_W;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
`ifdef BLOB_8CONN_EN
  localparam int NB = 4;
`else
  localparam int NB = 2;
`endif
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [LBL_W:0]    NF_FULL   = (LBL_W+1)'(MAX_LABELS);
  localparam logic [LBL_W-1:0]  K_LAST    = '1;
  localparam logic [AREA_W-1:0] BIG_MIN_A = AREA_W'(BIG_MIN);

  typedef enum logic [2:0] {S_IDLE, S_PROC, S_MERGE, S_FINDMAX, S_CLASSIFY, S_OUTPUT} state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [LBL_W:0]    next_free_q, next_free_d;
  logic [LBL_W-1:0]  k_q, k_d;
  logic [AREA_W-1:0] max_area_q, max_area_d;
  logic [7:0]        cnt_q, cnt_d, big_q, big_d, small_q, small_d;
  logic [7:0]        out_count_q, out_count_d, out_big_q, out_big_d, out_small_q, out_small_d;
  logic              valid_q, valid_d, ovf_q, ovf_d;
  logic [AREA_W-1:0] area_q [MAX_LABELS];
  logic [AREA_W-1:0] area_d [MAX_LABELS];
  logic [LBL_W-1:0]  parent_q [MAX_LABELS];
  logic [LBL_W-1:0]  parent_d [MAX_LABELS];
  logic [LBL_W-1:0]  line_q [IMG_W];
  logic [LBL_W-1:0]  line_d [IMG_W];
`ifdef BLOB_8CONN_EN
  logic [LBL_W-1:0]  up_prev_q, up_prev_d;
  logic [COL_W-1:0]  ur_idx;
`endif

  logic             start, take;
  logic [COL_W-1:0] pc;
  logic [ROW_W-1:0] pr;
  logic [LBL_W-1:0] nb [NB];
  logic [LBL_W-1:0] min_lbl, lbl, pa, pm;

  function automatic logic [AREA_W-1:0] area_add(input logic [AREA_W-1:0] a,
                                                 input logic [AREA_W-1:0] b);
    logic [AREA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AREA_W] ? '1 : s[AREA_W-1:0];
  endfunction

  function automatic logic [7:0] cnt_inc(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  // Next-state logic: pixel labelling, the three table sweeps and output capture.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    next_free_d = next_free_q;
    k_d         = k_q;
    max_area_d  = max_area_q;
    cnt_d       = cnt_q;
    big_d       = big_q;
    small_d     = small_q;
    out_count_d = out_count_q;
    out_big_d   = out_big_q;
    out_small_d = out_small_q;
    valid_d     = 1'b0;
    ovf_d       = ovf_q;
    area_d      = area_q;
    parent_d    = parent_q;
    line_d      = line_q;
`ifdef BLOB_8CONN_EN
    up_prev_d   = up_prev_q;
    ur_idx      = '0;
`endif
    pc      = col_q;
    pr      = row_q;
    min_lbl = '0;
    lbl     = '0;
    pa      = '0;
    pm      = '0;
    for (int i = 0; i < NB; i++) nb[i] = '0;

    start = i_valid && i_sof && (state_q == S_IDLE || state_q == S_PROC);
    take  = start || (i_valid && state_q == S_PROC);

    if (start) begin
      for (int i = 0; i < MAX_LABELS; i++) begin
        area_d[i]   = '0;
        parent_d[i] = '0;
      end
      for (int i = 0; i < IMG_W; i++) line_d[i] = '0;
      next_free_d = (LBL_W+1)'(1);
      ovf_d       = 1'b0;
      pc          = '0;
      pr          = '0;
      state_d     = S_PROC;
`ifdef BLOB_8CONN_EN
      up_prev_d   = '0;
`endif
    end

    case (state_q)
      S_MERGE: begin
        pa = parent_q[k_q];
        if (pa != k_q) begin
          area_d[pa]  = area_add(area_q[pa], area_q[k_q]);
          area_d[k_q] = '0;
        end
        if (k_q == LBL_W'(1)) begin
          state_d    = S_FINDMAX;
          max_area_d = '0;
        end
        k_d = (k_q == LBL_W'(1)) ? LBL_W'(1) : k_q - LBL_W'(1);
      end
      S_FINDMAX: begin
        if (area_q[k_q] > max_area_q) max_area_d = area_q[k_q];
        if (k_q == K_LAST) begin
          state_d = S_CLASSIFY;
          k_d     = LBL_W'(1);
          cnt_d   = '0;
          big_d   = '0;
          small_d = '0;
        end else begin
          k_d = k_q + LBL_W'(1);
        end
      end
      S_CLASSIFY: begin
        if (area_q[k_q] > (max_area_q >> NOISE_SHIFT)) begin
          cnt_d = cnt_inc(cnt_q);
          if (area_q[k_q] >= BIG_MIN_A) big_d = cnt_inc(big_q);
          else small_d = cnt_inc(small_q);
        end
        if (k_q == K_LAST) state_d = S_OUTPUT;
        else k_d = k_q + LBL_W'(1);
      end
      S_OUTPUT: begin
        out_count_d = cnt_q;
        out_big_d   = big_q;
        out_small_d = small_q;
        valid_d     = 1'b1;
        state_d     = S_IDLE;
      end
      default: ;
    endcase

    if (take) begin
      nb[0] = (pc != '0) ? line_d[pc - COL_W'(1)] : '0;
      nb[1] = (pr != '0) ? line_d[pc] : '0;
`ifdef BLOB_8CONN_EN
      ur_idx    = (pc == COL_LAST) ? pc : pc + COL_W'(1);
      nb[2]     = (pr != '0 && pc != '0) ? up_prev_q : '0;
      nb[3]     = (pr != '0 && pc != COL_LAST) ? line_d[ur_idx] : '0;
      up_prev_d = line_d[pc];
`endif
      if (i_pixel) begin
        for (int i = 0; i < NB; i++)
          if (nb[i] != '0 && (min_lbl == '0 || nb[i] < min_lbl)) min_lbl = nb[i];
        if (min_lbl == '0) begin
          if (next_free_d == NF_FULL) begin
            ovf_d = 1'b1;
          end else begin
            lbl           = next_free_d[LBL_W-1:0];
            area_d[lbl]   = AREA_W'(1);
            parent_d[lbl] = lbl;
            next_free_d   = next_free_d + (LBL_W+1)'(1);
          end
        end else begin
          lbl         = min_lbl;
          area_d[lbl] = area_add(area_d[lbl], AREA_W'(1));
          for (int i = 0; i < NB; i++) begin
            if (nb[i] != '0 && nb[i] != min_lbl) begin
              pa = parent_d[nb[i]];
              pm = parent_d[min_lbl];
              if (pa > pm) parent_d[pa] = pm;
              else if (pm > pa) parent_d[pm] = pa;
            end
          end
        end
      end
      line_d[pc] = lbl;
      if (pc == COL_LAST) begin
        col_d = '0;
        if (pr == ROW_LAST) begin
          state_d = S_MERGE;
          k_d     = K_LAST;
        end else begin
          row_d = pr + ROW_W'(1);
        end
      end else begin
        col_d = pc + COL_W'(1);
        row_d = pr;
      end
    end
  end

  // State and table registers, all cleared asynchronously by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      next_free_q <= (LBL_W+1)'(1);
      k_q         <= '0;
      max_area_q  <= '0;
      cnt_q       <= '0;
      big_q       <= '0;
      small_q     <= '0;
      out_count_q <= '0;
      out_big_q   <= '0;
      out_small_q <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      area_q      <= '{default: '0};
      parent_q    <= '{default: '0};
      line_q      <= '{default: '0};
`ifdef BLOB_8CONN_EN
      up_prev_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      next_free_q <= next_free_d;
      k_q         <= k_d;
      max_area_q  <= max_area_d;
      cnt_q       <= cnt_d;
      big_q       <= big_d;
      small_q     <= small_d;
      out_count_q <= out_count_d;
      out_big_q   <= out_big_d;
      out_small_q <= out_small_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      area_q      <= area_d;
      parent_q    <= parent_d;
      line_q      <= line_d;
`ifdef BLOB_8CONN_EN
      up_prev_q   <= up_prev_d;
`endif
    end
  end

  assign o_busy     = (state_q != S_IDLE) || valid_q;
  assign o_valid    = valid_q;
  assign o_count    = out_count_q;
  assign o_bigger   = out_big_q;
  assign o_smaller  = out_small_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_blob_classifier_param.sv
// Directed bench for blob_classifier_param on an 8x8 image with 3-bit labels.
// Each frame is an 8x8 bitmap where bit r*8+c is pixel (row r, col c).
module tb_blob_classifier_param;
  localparam int W   = 8;
  localparam int H   = 8;
  localparam int LW  = 3;
  localparam int BIG = 10;
  localparam int LAT = 3 * ((2 ** LW) - 1) + 1;

  logic       i_clk = 1'b0;
  logic       i_rst, i_valid, i_sof, i_pixel;
  logic       o_busy, o_valid, o_overflow;
  logic [7:0] o_count, o_bigger, o_smaller;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int p0;
  int lat;

  blob_classifier_param #(
    .IMG_W(W), .IMG_H(H), .LBL_W(LW), .AREA_W(20), .NOISE_SHIFT(3), .BIG_MIN(BIG)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sof(i_sof), .i_pixel(i_pixel),
    .o_busy(o_busy), .o_valid(o_valid), .o_count(o_count), .o_bigger(o_bigger),
    .o_smaller(o_smaller), .o_overflow(o_overflow)
  );

  // Free-running clock, period 10.
  always #5 i_clk = ~i_clk;

  // Counts result pulses so that duplicate or missing o_valid can be detected.
  always @(negedge i_clk) if (o_valid) pulses++;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Streams one frame (optionally with idle gaps), then waits for o_valid.
  task automatic applyStimulus(input logic [63:0] img, input bit stall, output int cycles);
    for (int idx = 0; idx < W * H; idx++) begin
      if (stall && (idx % 5 == 3)) begin
        i_valid = 1'b0; i_sof = 1'b1; i_pixel = 1'b1;
        @(posedge i_clk); #1;
      end
      i_valid = 1'b1; i_sof = (idx == 0); i_pixel = img[idx];
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0; i_sof = 1'b0; i_pixel = 1'b0;
    cycles = 0;
    while (!o_valid && cycles < 200) begin
      @(posedge i_clk); #1;
      cycles++;
    end
  endtask

  task automatic runFrame(input string tag, input logic [63:0] img, input bit stall,
                          input int ec, input int eb, input int es, input int eo);
    int c;
    applyStimulus(img, stall, c);
    checkOutput({tag, ".latency"}, c, LAT);
    checkOutput({tag, ".busy_at_valid"}, {31'd0, o_busy}, 1);
    checkOutput({tag, ".count"}, {24'd0, o_count}, ec);
    checkOutput({tag, ".bigger"}, {24'd0, o_bigger}, eb);
    checkOutput({tag, ".smaller"}, {24'd0, o_smaller}, es);
    checkOutput({tag, ".overflow"}, {31'd0, o_overflow}, eo);
    @(posedge i_clk); #1;
    checkOutput({tag, ".valid_pulse"}, {31'd0, o_valid}, 0);
    checkOutput({tag, ".busy_after"}, {31'd0, o_busy}, 0);
    checkOutput({tag, ".count_hold"}, {24'd0, o_count}, ec);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_pixel = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset.busy", {31'd0, o_busy}, 0);
    checkOutput("reset.valid", {31'd0, o_valid}, 0);
    checkOutput("reset.count", {24'd0, o_count}, 0);
    checkOutput("reset.overflow", {31'd0, o_overflow}, 0);
    i_rst = 1'b0;

    // Pixels without a start-of-frame are ignored while idle.
    i_valid = 1'b1; i_sof = 1'b0; i_pixel = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("idle_ignore.busy", {31'd0, o_busy}, 0);
    i_valid = 1'b0;
    @(posedge i_clk); #1;

    runFrame("zero", 64'h0000_0000_0000_0000, 1'b0, 0, 0, 0, 0);
    runFrame("sq_2x2", 64'h0060_6000_0F0F_0F0F, 1'b0, 2, 1, 1, 0);
    runFrame("sq_2x2_stall", 64'h0060_6000_0F0F_0F0F, 1'b1, 2, 1, 1, 0);
    runFrame("sq_noise", 64'h0040_0000_0F0F_0F0F, 1'b0, 1, 1, 0, 0);
    runFrame("u_shape", 64'h0000_1E12_1212_1212, 1'b0, 1, 1, 0, 0);
`ifdef BLOB_8CONN_EN
    runFrame("diag", 64'h0000_0000_0000_0201, 1'b0, 1, 0, 1, 0);
`else
    runFrame("diag", 64'h0000_0000_0000_0201, 1'b0, 2, 0, 2, 0);
`endif
    runFrame("sparse", 64'h0055_0055_0055_0055, 1'b0, 7, 0, 7, 1);
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("sparse.overflow_hold", {31'd0, o_overflow}, 1);
    checkOutput("sparse.count_hold_idle", {24'd0, o_count}, 7);

    // Reset in the middle of a frame discards it.
    for (int idx = 0; idx < 20; idx++) begin
      i_valid = 1'b1; i_sof = (idx == 0); i_pixel = 1'b1;
      @(posedge i_clk); #1;
    end
    checkOutput("midreset.busy_before", {31'd0, o_busy}, 1);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("midreset.busy", {31'd0, o_busy}, 0);
    checkOutput("midreset.count", {24'd0, o_count}, 0);
    checkOutput("midreset.overflow", {31'd0, o_overflow}, 0);
    i_valid = 1'b0; i_sof = 1'b0; i_pixel = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    p0 = pulses;
    runFrame("blob3x3", 64'h0000_001C_1C1C_0000, 1'b0, 1, 0, 1, 0);
    checkOutput("blob3x3.pulses", pulses - p0, 1);

    // A second start-of-frame mid-frame aborts and restarts.
    p0 = pulses;
    for (int idx = 0; idx < 10; idx++) begin
      i_valid = 1'b1; i_sof = (idx == 0); i_pixel = 1'b1;
      @(posedge i_clk); #1;
    end
    runFrame("abort", 64'h0000_0000_0000_0303, 1'b0, 1, 0, 1, 0);
    checkOutput("abort.pulses", pulses - p0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
